// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for sync_fifo: drains a fixed-length burst onto a valid/ready stream,
// hiding the FIFO's one-cycle read latency behind a 2-entry output buffer.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 30,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  burst_start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  words_left,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

    state_e                state_q;
    logic [LEN_WIDTH-1:0]  rdLeft_q;
    logic [LEN_WIDTH-1:0]  wordsLeft_q;
    logic                  inflight_q;
    logic                  inflightLast_q;
    logic [1:0]            occ_q;
    logic [DATA_WIDTH-1:0] headData_q;
    logic [DATA_WIDTH-1:0] tailData_q;
    logic                  headLast_q;
    logic                  tailLast_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pop;
    logic [2:0]            pending;

    // A read may issue only if buffered plus in-flight words, less the one leaving now, stay below 2.
    assign pop     = (occ_q != 2'd0) && m_ready;
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q};
    assign fifo_rd = (state_q == READ) && !fifo_empty && (rdLeft_q != '0)
                     && (pending < (3'd2 + {2'b00, pop}));

    assign busy       = busy_q;
    assign done       = done_q;
    assign words_left = wordsLeft_q;
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = headData_q;
    assign m_last     = m_valid && headLast_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rdLeft_q       <= '0;
            wordsLeft_q    <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            occ_q          <= 2'd0;
            headData_q     <= '0;
            tailData_q     <= '0;
            headLast_q     <= 1'b0;
            tailLast_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= fifo_rd;
            if (fifo_rd) begin
                inflightLast_q <= (rdLeft_q == LEN_WIDTH'(1));
            end

            if (pop && (wordsLeft_q != '0)) begin
                wordsLeft_q <= wordsLeft_q - LEN_WIDTH'(1);
            end

            case (state_q)
                IDLE: begin
                    if (burst_start && (burst_len != '0)) begin
                        state_q     <= READ;
                        rdLeft_q    <= burst_len;
                        wordsLeft_q <= burst_len;
                        busy_q      <= 1'b1;
                    end
                end
                READ: begin
                    if (fifo_rd) begin
                        rdLeft_q <= rdLeft_q - LEN_WIDTH'(1);
                        if (rdLeft_q == LEN_WIDTH'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && headLast_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // The word returned by last cycle's read lands in whichever slot keeps arrival order.
            if (inflight_q && pop) begin
                if (occ_q == 2'd2) begin
                    headData_q <= tailData_q;
                    headLast_q <= tailLast_q;
                    tailData_q <= fifo_data;
                    tailLast_q <= inflightLast_q;
                end else begin
                    headData_q <= fifo_data;
                    headLast_q <= inflightLast_q;
                end
            end else if (inflight_q) begin
                if (occ_q == 2'd0) begin
                    headData_q <= fifo_data;
                    headLast_q <= inflightLast_q;
                end else begin
                    tailData_q <= fifo_data;
                    tailLast_q <= inflightLast_q;
                end
                occ_q <= occ_q + 2'd1;
            end else if (pop) begin
                headData_q <= tailData_q;
                headLast_q <= tailLast_q;
                occ_q      <= occ_q - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural one-cycle-latency FIFO on its read side.
module tb_fifo_burst_reader;

    logic        clk;
    logic        rst_n;
    logic        burst_start;
    logic [7:0]  burst_len;
    logic        busy;
    logic        done;
    logic [7:0]  words_left;
    logic        fifo_rd;
    logic [29:0] fifoData;
    logic        fifoEmpty;
    logic        m_valid;
    logic [29:0] m_data;
    logic        m_last;
    logic        m_ready;

    int checks = 0;
    int errors = 0;

    logic [29:0] fifoMem [0:63];
    int          pushCount = 0;
    int          popIdx = 0;

    logic [29:0] capData [0:63];
    logic        capLast [0:63];
    int          capCount = 0;
    int          doneCount = 0;
    int          emptyRdErr = 0;
    int          overflowErr = 0;
    int          holdErr = 0;
    int          outstanding = 0;
    bit          stallPrev = 1'b0;
    logic [29:0] stallData;
    logic        stallLast;

    fifo_burst_reader #(.DATA_WIDTH(30), .LEN_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .words_left  (words_left),
        .fifo_rd     (fifo_rd),
        .fifo_data   (fifoData),
        .fifo_empty  (fifoEmpty),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifoEmpty = (pushCount == popIdx);

    // Behavioural sync_fifo read port: data appears one edge after an accepted read.
    always @(posedge clk) begin
        if (fifo_rd && !fifoEmpty) begin
            fifoData <= fifoMem[popIdx];
            popIdx   <= popIdx + 1;
        end
    end

    // Mid-cycle monitor: records handshakes, done pulses and read-side protocol violations.
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 0;
            stallPrev   = 1'b0;
        end else begin
            if (fifo_rd && fifoEmpty) emptyRdErr++;
            if (fifo_rd && ((outstanding - ((m_valid && m_ready) ? 1 : 0)) >= 2)) overflowErr++;
            if (stallPrev && (!m_valid || m_data !== stallData || m_last !== stallLast)) holdErr++;
            stallPrev = m_valid && !m_ready;
            stallData = m_data;
            stallLast = m_last;
            if (m_valid && m_ready) begin
                capData[capCount] = m_data;
                capLast[capCount] = m_last;
                capCount++;
                outstanding--;
            end
            if (fifo_rd && !fifoEmpty) outstanding++;
            if (done) doneCount++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input logic [29:0] w);
        fifoMem[pushCount] = w;
        pushCount++;
    endtask

    task automatic waitForDone(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; burst_start = 1'b1; burst_len = 8'd5; m_ready = 1'b1;
        tick(3);
        checks += 7;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
        if (fifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_fifo_rd: got %b, expected 0", fifo_rd); end
        if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %b, expected 0", m_valid); end
        if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_last: got %b, expected 0", m_last); end
        if (m_data !== 30'd0) begin errors++; $display("[TB] FAIL reset_m_data: got %0d, expected 0", m_data); end
        if (words_left !== 8'd0) begin errors++; $display("[TB] FAIL reset_words_left: got %0d, expected 0", words_left); end
        burst_start = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_basic_burst();
        logic [8:0]  expRd    = 9'b0_0000_1111;
        logic [8:0]  expValid = 9'b0_0011_1100;
        logic [8:0]  expLast  = 9'b0_0010_0000;
        logic [8:0]  expDone  = 9'b0_0100_0000;
        logic [8:0]  expBusy  = 9'b0_0011_1111;
        logic [29:0] expData [0:8];
        expData[2] = 30'd512; expData[3] = 30'd2222; expData[4] = 30'd312; expData[5] = 30'd404;
        pushWord(30'd512); pushWord(30'd2222); pushWord(30'd312); pushWord(30'd404);
        m_ready = 1'b1; burst_start = 1'b1; burst_len = 8'd4;
        tick(1);
        burst_start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks += 5;
            if (fifo_rd !== expRd[k-1]) begin errors++; $display("[TB] FAIL basic_fifo_rd cycle %0d: got %b, expected %b", k, fifo_rd, expRd[k-1]); end
            if (m_valid !== expValid[k-1]) begin errors++; $display("[TB] FAIL basic_m_valid cycle %0d: got %b, expected %b", k, m_valid, expValid[k-1]); end
            if (m_last !== expLast[k-1]) begin errors++; $display("[TB] FAIL basic_m_last cycle %0d: got %b, expected %b", k, m_last, expLast[k-1]); end
            if (done !== expDone[k-1]) begin errors++; $display("[TB] FAIL basic_done cycle %0d: got %b, expected %b", k, done, expDone[k-1]); end
            if (busy !== expBusy[k-1]) begin errors++; $display("[TB] FAIL basic_busy cycle %0d: got %b, expected %b", k, busy, expBusy[k-1]); end
            if (expValid[k-1]) begin
                checks++;
                if (m_data !== expData[k-1]) begin errors++; $display("[TB] FAIL basic_m_data cycle %0d: got %0d, expected %0d", k, m_data, expData[k-1]); end
            end
            if (k == 1) begin
                checks++;
                if (words_left !== 8'd4) begin errors++; $display("[TB] FAIL basic_words_left_start: got %0d, expected 4", words_left); end
            end
        end
        checks++;
        if (words_left !== 8'd0) begin errors++; $display("[TB] FAIL basic_words_left_end: got %0d, expected 0", words_left); end
        tick(1);
    endtask

    task automatic test_backpressure();
        logic [7:0]  readyPat = 8'b1011_0001;
        logic [29:0] expWords [0:3];
        int          base = capCount;
        int          doneBase = doneCount;
        bit          seen;
        expWords[0] = 30'd5; expWords[1] = 30'd6; expWords[2] = 30'd7; expWords[3] = 30'd8;
        pushWord(30'd5); pushWord(30'd6); pushWord(30'd7); pushWord(30'd8);
        burst_start = 1'b1; burst_len = 8'd4;
        tick(1);
        burst_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_ready = readyPat[i];
            tick(1);
        end
        m_ready = 1'b1;
        waitForDone(40, seen);
        tick(3);
        checks += 5;
        if (!seen) begin errors++; $display("[TB] FAIL bp_done_timeout: got no done, expected done within 40 cycles"); end
        if (capCount - base !== 4) begin errors++; $display("[TB] FAIL bp_word_count: got %0d, expected 4", capCount - base); end
        if (doneCount - doneBase !== 1) begin errors++; $display("[TB] FAIL bp_done_pulses: got %0d, expected 1", doneCount - doneBase); end
        if (holdErr !== 0) begin errors++; $display("[TB] FAIL bp_hold_stable: got %0d violations, expected 0", holdErr); end
        if (overflowErr !== 0) begin errors++; $display("[TB] FAIL bp_read_limit: got %0d violations, expected 0", overflowErr); end
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (capData[base+i] !== expWords[i]) begin errors++; $display("[TB] FAIL bp_data word %0d: got %0d, expected %0d", i, capData[base+i], expWords[i]); end
            if (capLast[base+i] !== (i == 3)) begin errors++; $display("[TB] FAIL bp_last word %0d: got %b, expected %b", i, capLast[base+i], (i == 3)); end
        end
    endtask

    task automatic test_empty_stall();
        int base = capCount;
        int doneBase = doneCount;
        bit seen;
        m_ready = 1'b1; burst_start = 1'b1; burst_len = 8'd3;
        tick(1);
        burst_start = 1'b0;
        tick(9);
        checks += 3;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_busy: got %b, expected 1", busy); end
        if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_m_valid: got %b, expected 0", m_valid); end
        if (fifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL stall_fifo_rd: got %b, expected 0", fifo_rd); end
        pushWord(30'd7);
        tick(1);
        pushWord(30'd8);
        tick(1);
        pushWord(30'd9);
        waitForDone(30, seen);
        tick(3);
        checks += 4;
        if (!seen) begin errors++; $display("[TB] FAIL stall_done_timeout: got no done, expected done within 30 cycles"); end
        if (capCount - base !== 3) begin errors++; $display("[TB] FAIL stall_word_count: got %0d, expected 3", capCount - base); end
        if (doneCount - doneBase !== 1) begin errors++; $display("[TB] FAIL stall_done_pulses: got %0d, expected 1", doneCount - doneBase); end
        if (emptyRdErr !== 0) begin errors++; $display("[TB] FAIL stall_rd_when_empty: got %0d, expected 0", emptyRdErr); end
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (capData[base+i] !== 30'(7 + i)) begin errors++; $display("[TB] FAIL stall_data word %0d: got %0d, expected %0d", i, capData[base+i], 7 + i); end
            if (capLast[base+i] !== (i == 2)) begin errors++; $display("[TB] FAIL stall_last word %0d: got %b, expected %b", i, capLast[base+i], (i == 2)); end
        end
    endtask

    task automatic test_ignored_commands();
        int base;
        int doneBase = doneCount;
        bit seen;
        m_ready = 1'b1; burst_start = 1'b1; burst_len = 8'd0;
        tick(1);
        burst_start = 1'b0;
        tick(3);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_zero_busy: got %b, expected 0", busy); end
        if (doneCount - doneBase !== 0) begin errors++; $display("[TB] FAIL ignore_zero_done: got %0d, expected 0", doneCount - doneBase); end
        pushWord(30'd21); pushWord(30'd22); pushWord(30'd23);
        base = capCount;
        burst_start = 1'b1; burst_len = 8'd2;
        tick(1);
        burst_len = 8'd9;
        tick(1);
        burst_start = 1'b0;
        checks++;
        if (words_left !== 8'd2) begin errors++; $display("[TB] FAIL ignore_busy_words_left: got %0d, expected 2", words_left); end
        waitForDone(30, seen);
        tick(3);
        checks += 6;
        if (!seen) begin errors++; $display("[TB] FAIL ignore_done_timeout: got no done, expected done within 30 cycles"); end
        if (capCount - base !== 2) begin errors++; $display("[TB] FAIL ignore_word_count: got %0d, expected 2", capCount - base); end
        if (capData[base] !== 30'd21 || capLast[base] !== 1'b0) begin errors++; $display("[TB] FAIL ignore_word0: got %0d/%b, expected 21/0", capData[base], capLast[base]); end
        if (capData[base+1] !== 30'd22 || capLast[base+1] !== 1'b1) begin errors++; $display("[TB] FAIL ignore_word1: got %0d/%b, expected 22/1", capData[base+1], capLast[base+1]); end
        if (pushCount - popIdx !== 1) begin errors++; $display("[TB] FAIL ignore_fifo_left: got %0d, expected 1", pushCount - popIdx); end
        if (words_left !== 8'd0) begin errors++; $display("[TB] FAIL ignore_words_left_end: got %0d, expected 0", words_left); end
        base = capCount;
        burst_start = 1'b1; burst_len = 8'd1;
        tick(1);
        burst_start = 1'b0;
        waitForDone(30, seen);
        tick(2);
        checks += 2;
        if (!seen) begin errors++; $display("[TB] FAIL single_done_timeout: got no done, expected done within 30 cycles"); end
        if (capData[base] !== 30'd23 || capLast[base] !== 1'b1) begin errors++; $display("[TB] FAIL single_word: got %0d/%b, expected 23/1", capData[base], capLast[base]); end
    endtask

    task automatic test_mid_burst_reset();
        int base;
        int doneBase;
        bit reached = 1'b0;
        bit seen;
        for (int i = 0; i < 6; i++) pushWord(30'(31 + i));
        base = capCount;
        m_ready = 1'b1; burst_start = 1'b1; burst_len = 8'd4;
        tick(1);
        burst_start = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            @(negedge clk);
            #1;
            if (capCount - base >= 2) reached = 1'b1;
        end
        checks++;
        if (!reached) begin errors++; $display("[TB] FAIL mid_reset_two_words: got %0d words, expected 2", capCount - base); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks += 7;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_busy: got %b, expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_done: got %b, expected 0", done); end
        if (fifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_fifo_rd: got %b, expected 0", fifo_rd); end
        if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_m_valid: got %b, expected 0", m_valid); end
        if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_m_last: got %b, expected 0", m_last); end
        if (m_data !== 30'd0) begin errors++; $display("[TB] FAIL mid_reset_m_data: got %0d, expected 0", m_data); end
        if (words_left !== 8'd0) begin errors++; $display("[TB] FAIL mid_reset_words_left: got %0d, expected 0", words_left); end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        base = capCount;
        doneBase = doneCount;
        burst_start = 1'b1; burst_len = 8'd2;
        tick(1);
        burst_start = 1'b0;
        waitForDone(30, seen);
        tick(3);
        checks += 5;
        if (!seen) begin errors++; $display("[TB] FAIL after_reset_done_timeout: got no done, expected done within 30 cycles"); end
        if (capCount - base !== 2) begin errors++; $display("[TB] FAIL after_reset_word_count: got %0d, expected 2", capCount - base); end
        if (capData[base] !== 30'd35 || capLast[base] !== 1'b0) begin errors++; $display("[TB] FAIL after_reset_word0: got %0d/%b, expected 35/0", capData[base], capLast[base]); end
        if (capData[base+1] !== 30'd36 || capLast[base+1] !== 1'b1) begin errors++; $display("[TB] FAIL after_reset_word1: got %0d/%b, expected 36/1", capData[base+1], capLast[base+1]); end
        if (doneCount - doneBase !== 1) begin errors++; $display("[TB] FAIL after_reset_done_pulses: got %0d, expected 1", doneCount - doneBase); end
    endtask

    task automatic test_protocol_totals();
        checks += 3;
        if (emptyRdErr !== 0) begin errors++; $display("[TB] FAIL total_rd_when_empty: got %0d, expected 0", emptyRdErr); end
        if (overflowErr !== 0) begin errors++; $display("[TB] FAIL total_read_limit: got %0d, expected 0", overflowErr); end
        if (holdErr !== 0) begin errors++; $display("[TB] FAIL total_hold_stable: got %0d, expected 0", holdErr); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000 ns");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        rst_n = 1'b0;
        burst_start = 1'b0;
        burst_len = 8'd0;
        m_ready = 1'b0;
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_empty_stall();
        test_ignored_commands();
        test_mid_burst_reset();
        test_protocol_totals();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side controller for sync_fifo. On command, it drains a fixed-length burst of words from the FIFO and presents them on a valid/ready stream with a last-word marker. It hides the FIFO's one-cycle read latency behind a 2-entry output buffer, which lets it sustain one word per cycle under no backpressure. It sits between sync_fifo (rd/data_out/empty) and any downstream consumer.

Parameters:
DATA_WIDTH, 30, word width; matches sync_fifo data_in/data_out.
LEN_WIDTH, 8, width of burst length; maximum burst is 2^LEN_WIDTH-1 words.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
burst_start  input  1  one-cycle request to start a burst; sampled only in IDLE.
burst_len  input  LEN_WIDTH  number of words to read; sampled with burst_start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse after the final word is handshaken.
words_left  output  LEN_WIDTH  words of the current burst not yet handshaken on the output.
fifo_rd  output  1  read strobe to sync_fifo rd.
fifo_data  input  DATA_WIDTH  sync_fifo data_out.
fifo_empty  input  1  sync_fifo empty.
m_valid  output  1  output word valid.
m_data  output  DATA_WIDTH  output word.
m_last  output  1  high with the final word of the burst.
m_ready  input  1  downstream accepts when high together with m_valid.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; busy, done, fifo_rd, m_valid, m_last=0; m_data=0; words_left=0.
  - Output buffer and all counters are cleared.
  - Effective immediately and mid-burst. Words already popped from the FIFO are discarded, not re-pushed.
- FIFO timing contract:
  - fifo_data is valid on the rising edge one cycle after the edge where fifo_rd=1 and fifo_empty=0.
  - fifo_rd is never asserted while fifo_empty=1.
- States:
  - IDLE:
    - burst_start=1 with burst_len!=0 -> READ. Latch len into rd_left and words_left; busy=1 next cycle.
    - burst_len=0 is ignored: no busy, no done.
  - READ:
    - fifo_rd = !fifo_empty && rd_left!=0 && (occ + inflight - pop) < 2.
    - occ is buffer occupancy (0..2); inflight is fifo_rd registered from the previous cycle; pop = m_valid && m_ready.
    - rd_left decrements on each fifo_rd. When rd_left reaches 0 -> DRAIN.
  - DRAIN:
    - No reads.
    - The handshake of the word with m_last=1 -> IDLE. busy=0 and done=1 for exactly one cycle, both on the following cycle.
- Buffer:
  - 2-entry FIFO of DATA_WIDTH plus a last bit. A returned word is written at the edge after its fifo_rd.
  - m_valid = occ!=0. m_data and m_last come from the head entry.
  - While m_valid && !m_ready, m_data and m_last hold stable.
  - A simultaneous write and pop with occ=1 or 2 keeps ordering. Overflow is impossible by the fifo_rd rule.
- m_last is tagged on the word read when rd_left was 1.
- words_left decrements on each pop and reaches 0 on the final pop.
- burst_start while busy is ignored entirely; the latched length is unaffected.
- The FIFO empty mid-burst stalls reads without error. The burst resumes when fifo_empty drops; there is no timeout.
- Throughput: with FIFO non-empty and m_ready=1, the first m_valid appears 2 cycles after burst_start. After that, one word per cycle.
- Width rules: counters are LEN_WIDTH, unsigned, and never wrap. They are only decremented when non-zero.

Test Plan:
- Reset: hold rst_n=0 with burst_start=1 -> busy, done, fifo_rd, m_valid, m_last=0; m_data=0; words_left=0.
- Basic burst:
  - Stimulus: preload FIFO with 512, 2222, 312, 404; burst_len=4; m_ready=1.
  - Response: fifo_rd high 4 consecutive cycles; m_data=512, 2222, 312, 404 on consecutive cycles; m_last only with 404; done one cycle after the 404 handshake; busy low the same cycle.
- Backpressure:
  - Stimulus: preload 5, 6, 7, 8; burst_len=4; m_ready pattern 1,0,0,0,1,1,0,1.
  - Response: each word delivered exactly once in order; m_data held while stalled; fifo_rd low whenever 2 words are buffered or in flight.
- Empty stall:
  - Stimulus: FIFO empty; burst_len=3; write 7 at +10 cycles, then 8 and 9.
  - Response: fifo_rd never high while fifo_empty=1; outputs 7, 8, 9 with m_last on 9; done pulses once.
- Ignored commands:
  - Stimulus: burst_len=0 start; then start with len=9 while a len=2 burst is busy.
  - Response: the first produces no busy; the second does not change words_left; exactly 2 words are output.
- Mid-burst reset:
  - Stimulus: assert rst_n=0 after 2 of 4 words are handshaken.
  - Response: all outputs 0 immediately. A subsequent len=2 burst returns the next two FIFO words with correct m_last and done.
